record_play_ctrl: RTL and testbench

RECORD_PLAY_CTRL -- requirements
Module: record_play_ctrl

---
 rtl/recorder_pkg.sv | 18 +
 rtl/note_seq_ptr.sv | 53 +++++
 rtl/record_play_ctrl.sv | 173 +++++++++++++++++
 tb/tb_record_play_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// Shared definitions for the record/playback sequencer: default widths,
// note RAM depth and the controller state encoding.
package recorder_pkg;

    localparam int RAM_DEPTH  = 64;
    localparam int ADDR_W_DEF = $clog2(RAM_DEPTH);
    localparam int DATA_W_DEF = 32;
    localparam int NOTE_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REC_ARM  = 3'd1,
        ST_RECORD   = 3'd2,
        ST_PLAY_ARM = 3'd3,
        ST_PLAY     = 3'd4
    } state_t;

endpackage

// File: rtl/note_seq_ptr.sv
// Write pointer, read pointer and recorded length for the note sequencer.
// The write pointer and length advance together once per completed write;
// the read pointer loops over 0 .. length-1.
module note_seq_ptr
    import recorder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_clr,
    input  logic              wr_inc,
    input  logic              rd_clr,
    input  logic              rd_inc,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   length
);

    logic [ADDR_W:0] last_idx;

    assign last_idx = length - (ADDR_W+1)'(1);

    // Write pointer and length: cleared when a new recording is armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            length <= '0;
        end else if (wr_clr) begin
            wr_ptr <= '0;
            length <= '0;
        end else if (wr_inc) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            length <= length + (ADDR_W+1)'(1);
        end
    end

    // Read pointer: wraps after the last recorded note so playback loops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (rd_clr) begin
            rd_ptr <= '0;
        end else if (rd_inc) begin
            if ({1'b0, rd_ptr} == last_idx) begin
                rd_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/record_play_ctrl.sv
// Record/playback controller for a beat-timed note sequence.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  IDLE     | waiting for rec_req / play_req, RAM address parked at 0
//  REC_ARM  | recording armed, first beat starts the take (no write)
//  RECORD   | each beat writes note_in at the write pointer
//  PLAY_ARM | playback armed, first beat starts playback (no read)
//  PLAY     | each beat reads the next note, looping over the take
//
// A beat is sampled at a clock edge and the resulting RAM write or read
// occupies the following cycle, so ram_wren and ram_addr come straight from
// registers. The write pointer/length and the read pointer advance at the
// end of that access cycle. note_out loads the RAM data at the end of the
// read cycle (RAM data is valid one cycle after the address).
module record_play_ctrl
    import recorder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NOTE_W = NOTE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat,
    input  logic              rec_req,
    input  logic              play_req,
    input  logic              stop_req,
    input  logic [NOTE_W-1:0] note_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [NOTE_W-1:0] note_out,
    output logic [ADDR_W:0]   length,
    output logic [2:0]        state
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_LEN = (ADDR_W+1)'(DEPTH - 1);

    state_t              state_q;
    state_t              state_d;
    logic                wren_q;
    logic                rd_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NOTE_W-1:0]   note_q;

    logic                issue_wr;
    logic                issue_rd;
    logic                wr_clr;
    logic                rd_clr;
    logic                stop_hit;

    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;

    logic [DATA_W-NOTE_W-1:0] rdata_unused;

    assign rdata_unused = ram_rdata[DATA_W-1:NOTE_W];

    note_seq_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .wr_clr (wr_clr),
        .wr_inc (wren_q),
        .rd_clr (rd_clr),
        .rd_inc (rd_q),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .length (length)
    );

    // Next-state and access-issue decode; stop always beats a coincident beat.
    always_comb begin
        state_d  = state_q;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        wr_clr   = 1'b0;
        rd_clr   = 1'b0;
        stop_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rec_req) begin
                    state_d = ST_REC_ARM;
                    wr_clr  = 1'b1;
                end else if (play_req && (length != '0)) begin
                    state_d = ST_PLAY_ARM;
                    rd_clr  = 1'b1;
                end
            end
            ST_REC_ARM: begin
                if (stop_req) begin
                    state_d  = ST_IDLE;
                    stop_hit = 1'b1;
                end else if (beat) begin
                    state_d = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (stop_req) begin
                    state_d  = ST_IDLE;
                    stop_hit = 1'b1;
                end else if (wren_q && (length == LAST_LEN)) begin
                    // The write in flight fills the RAM.
                    state_d = ST_IDLE;
                end else if (beat) begin
                    issue_wr = 1'b1;
                end
            end
            ST_PLAY_ARM: begin
                if (stop_req) begin
                    state_d  = ST_IDLE;
                    stop_hit = 1'b1;
                end else if (beat) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop_req) begin
                    state_d  = ST_IDLE;
                    stop_hit = 1'b1;
                end else if (beat) begin
                    issue_rd = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, access strobes, captured write data and the playback note.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wren_q  <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            note_q  <= '0;
        end else begin
            state_q <= state_d;
            wren_q  <= issue_wr;
            rd_q    <= issue_rd;
            if (issue_wr) begin
                wdata_q <= DATA_W'(note_in);
            end
            if (stop_hit) begin
                note_q <= '0;
            end else if (rd_q) begin
                note_q <= ram_rdata[NOTE_W-1:0];
            end
        end
    end

    // RAM address follows the pointer owned by the active mode.
    always_comb begin
        ram_addr = '0;
        case (state_q)
            ST_REC_ARM, ST_RECORD: ram_addr = wr_ptr;
            ST_PLAY_ARM, ST_PLAY:  ram_addr = rd_ptr;
            default:               ram_addr = '0;
        endcase
    end

    assign ram_wren  = wren_q;
    assign ram_wdata = wdata_q;
    assign note_out  = note_q;
    assign state     = state_q;

endmodule

// File: tb/tb_record_play_ctrl.sv
// Bench for record_play_ctrl with a synchronous note RAM model and a write
// scoreboard: expected writes are queued as beats are driven and checked
// when the DUT asserts ram_wren.
module tb_record_play_ctrl;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int NOTE_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              beat = 1'b0;
    logic              rec_req = 1'b0;
    logic              play_req = 1'b0;
    logic              stop_req = 1'b0;
    logic [NOTE_W-1:0] note_in = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_rdata = '0;
    logic [NOTE_W-1:0] note_out;
    logic [ADDR_W:0]   length;
    logic [2:0]        state;

    logic [DATA_W-1:0] mem [64];

    typedef logic [ADDR_W+DATA_W-1:0] wr_t;
    wr_t exp_wr[$];
    logic [ADDR_W-1:0] exp_raddr[$];
    logic [NOTE_W-1:0] exp_note[$];

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;

    record_play_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOTE_W(NOTE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .beat      (beat),
        .rec_req   (rec_req),
        .play_req  (play_req),
        .stop_req  (stop_req),
        .note_in   (note_in),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren),
        .ram_rdata (ram_rdata),
        .note_out  (note_out),
        .length    (length),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Write scoreboard: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && ram_wren) begin
            n_wr++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, no write expected", ram_addr, ram_wdata);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             ram_addr, ram_wdata, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rec();
        rec_req = 1'b1; cyc(1); rec_req = 1'b0; cyc(1);
    endtask

    task automatic pulse_play();
        play_req = 1'b1; cyc(1); play_req = 1'b0; cyc(1);
    endtask

    task automatic pulse_stop();
        stop_req = 1'b1; cyc(1); stop_req = 1'b0; cyc(1);
    endtask

    task automatic do_beat(input logic [NOTE_W-1:0] n);
        note_in = n; beat = 1'b1; cyc(1); beat = 1'b0; cyc(3);
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(2);
        checks += 5;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        if (length !== 7'd0) begin errors++; $display("FAIL reset_length: got %0d expected 0", length); end
        if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %0b expected 0", ram_wren); end
        if (note_out !== 10'd0) begin errors++; $display("FAIL reset_note: got %0h expected 0", note_out); end
        if (ram_addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", ram_addr); end
        reset = 1'b0; cyc(1);
        // reset in the middle of a recording
        pulse_rec();
        do_beat(10'h3ff);
        for (int i = 0; i < 5; i++) begin
            exp_wr.push_back({ADDR_W'(i), DATA_W'(10'h010 + i)});
            do_beat(10'h010 + NOTE_W'(i));
        end
        checks += 2;
        if (length !== 7'd5) begin errors++; $display("FAIL rec5_length: got %0d expected 5", length); end
        if (state !== 3'd2) begin errors++; $display("FAIL rec5_state: got %0d expected 2", state); end
        reset = 1'b1; beat = 1'b1; rec_req = 1'b1; cyc(1);
        reset = 1'b0; beat = 1'b0; rec_req = 1'b0;
        checks += 4;
        if (state !== 3'd0) begin errors++; $display("FAIL midrec_reset_state: got %0d expected 0", state); end
        if (length !== 7'd0) begin errors++; $display("FAIL midrec_reset_length: got %0d expected 0", length); end
        if (ram_wren !== 1'b0) begin errors++; $display("FAIL midrec_reset_wren: got %0b expected 0", ram_wren); end
        if (note_out !== 10'd0) begin errors++; $display("FAIL midrec_reset_note: got %0h expected 0", note_out); end
        cyc(2);
    endtask

    task automatic test_record();
        pulse_rec();
        checks += 3;
        if (state !== 3'd1) begin errors++; $display("FAIL rec_arm_state: got %0d expected 1", state); end
        if (length !== 7'd0) begin errors++; $display("FAIL rec_arm_length: got %0d expected 0", length); end
        if (ram_addr !== 6'd0) begin errors++; $display("FAIL rec_arm_addr: got %0h expected 0", ram_addr); end
        do_beat(10'h001);
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL record_state: got %0d expected 2", state); end
        exp_wr.push_back({6'd0, 32'h2}); do_beat(10'h002);
        exp_wr.push_back({6'd1, 32'h4}); do_beat(10'h004);
        exp_wr.push_back({6'd2, 32'h8}); do_beat(10'h008);
        pulse_stop();
        checks += 4;
        if (state !== 3'd0) begin errors++; $display("FAIL rec_stop_state: got %0d expected 0", state); end
        if (length !== 7'd3) begin errors++; $display("FAIL rec_length: got %0d expected 3", length); end
        if (ram_addr !== 6'd0) begin errors++; $display("FAIL idle_addr: got %0h expected 0", ram_addr); end
        if (exp_wr.size() != 0) begin errors++; $display("FAIL rec_writes_missing: got %0d pending expected 0", exp_wr.size()); end
    endtask

    task automatic test_loop();
        logic [NOTE_W-1:0] stored [3];
        logic [ADDR_W-1:0] a;
        logic [NOTE_W-1:0] n;
        stored[0] = 10'h2; stored[1] = 10'h4; stored[2] = 10'h8;
        pulse_play();
        checks += 2;
        if (state !== 3'd3) begin errors++; $display("FAIL play_arm_state: got %0d expected 3", state); end
        if (ram_addr !== 6'd0) begin errors++; $display("FAIL play_arm_addr: got %0h expected 0", ram_addr); end
        do_beat(10'h0);
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL play_state: got %0d expected 4", state); end
        for (int k = 0; k < 6; k++) begin
            exp_raddr.push_back(ADDR_W'(k % 3));
            exp_note.push_back(stored[k % 3]);
        end
        for (int k = 0; k < 6; k++) begin
            a = exp_raddr.pop_front();
            n = exp_note.pop_front();
            beat = 1'b1; cyc(1); beat = 1'b0;
            checks++;
            if (ram_addr !== a) begin errors++; $display("FAIL read_addr[%0d]: got %0h expected %0h", k, ram_addr, a); end
            cyc(1);
            checks++;
            if (note_out !== n) begin errors++; $display("FAIL note_out[%0d]: got %0h expected %0h", k, note_out, n); end
            cyc(2);
        end
        pulse_rec();
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL rec_in_play_ignored: got %0d expected 4", state); end
        pulse_stop();
        checks += 3;
        if (state !== 3'd0) begin errors++; $display("FAIL play_stop_state: got %0d expected 0", state); end
        if (note_out !== 10'd0) begin errors++; $display("FAIL play_stop_note: got %0h expected 0", note_out); end
        if (length !== 7'd3) begin errors++; $display("FAIL play_stop_length: got %0d expected 3", length); end
        // reset while a note is being played
        pulse_play(); do_beat(10'h0); do_beat(10'h0);
        checks++;
        if (note_out !== 10'h2) begin errors++; $display("FAIL replay_note: got %0h expected 2", note_out); end
        reset = 1'b1; cyc(1); reset = 1'b0;
        checks += 3;
        if (state !== 3'd0) begin errors++; $display("FAIL play_reset_state: got %0d expected 0", state); end
        if (note_out !== 10'd0) begin errors++; $display("FAIL play_reset_note: got %0h expected 0", note_out); end
        if (length !== 7'd0) begin errors++; $display("FAIL play_reset_length: got %0d expected 0", length); end
        cyc(1);
    endtask

    task automatic test_full();
        int n0;
        pulse_rec();
        do_beat(10'h0);
        n0 = n_wr;
        for (int k = 0; k < 69; k++) begin
            if (k < 64) exp_wr.push_back({ADDR_W'(k), DATA_W'(10'h100 + k)});
            do_beat(10'h100 + NOTE_W'(k));
            if (k == 62) begin
                checks++;
                if (state !== 3'd2) begin errors++; $display("FAIL full_63_state: got %0d expected 2", state); end
            end
            if (k == 63) begin
                checks += 2;
                if (state !== 3'd0) begin errors++; $display("FAIL full_64_state: got %0d expected 0", state); end
                if (length !== 7'd64) begin errors++; $display("FAIL full_64_length: got %0d expected 64", length); end
            end
        end
        checks += 3;
        if (n_wr - n0 != 64) begin errors++; $display("FAIL full_write_count: got %0d expected 64", n_wr - n0); end
        if (length !== 7'd64) begin errors++; $display("FAIL full_length: got %0d expected 64", length); end
        if (exp_wr.size() != 0) begin errors++; $display("FAIL full_writes_missing: got %0d pending expected 0", exp_wr.size()); end
    endtask

    task automatic test_collision();
        pulse_rec();
        do_beat(10'h0);
        exp_wr.push_back({6'd0, 32'h55}); do_beat(10'h055);
        note_in = 10'h066; stop_req = 1'b1; beat = 1'b1; cyc(1);
        stop_req = 1'b0; beat = 1'b0;
        checks += 2;
        if (ram_wren !== 1'b0) begin errors++; $display("FAIL stop_beat_wren: got %0b expected 0", ram_wren); end
        if (state !== 3'd0) begin errors++; $display("FAIL stop_beat_state: got %0d expected 0", state); end
        cyc(3);
        checks++;
        if (length !== 7'd1) begin errors++; $display("FAIL stop_beat_length: got %0d expected 1", length); end
        rec_req = 1'b1; play_req = 1'b1; cyc(1); rec_req = 1'b0; play_req = 1'b0;
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL rec_play_both: got %0d expected 1", state); end
        cyc(1);
        pulse_play();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL play_in_arm_ignored: got %0d expected 1", state); end
        pulse_stop();
        checks += 2;
        if (state !== 3'd0) begin errors++; $display("FAIL arm_stop_state: got %0d expected 0", state); end
        if (length !== 7'd0) begin errors++; $display("FAIL arm_stop_length: got %0d expected 0", length); end
    endtask

    task automatic test_empty();
        play_req = 1'b1; cyc(1); play_req = 1'b0;
        checks += 2;
        if (state !== 3'd0) begin errors++; $display("FAIL empty_play_state: got %0d expected 0", state); end
        if (ram_addr !== 6'd0) begin errors++; $display("FAIL empty_play_addr: got %0h expected 0", ram_addr); end
        cyc(2);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL empty_play_later: got %0d expected 0", state); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_record();
        test_loop();
        test_full();
        test_collision();
        test_empty();
        cyc(4);
        checks++;
        if (exp_wr.size() != 0) begin errors++; $display("FAIL final_writes_pending: got %0d expected 0", exp_wr.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
